// File: rtl/fp_min_seq.sv
`default_nettype none
// ============================================================================
// Module   : fp_min_seq
// Purpose  : Streams a programmed count of FP operands through one compare
//            datapath (zero-exponent flush) and returns their minimum.
// Revision : 1.0
// ============================================================================
module fp_min_seq #(
    parameter  int SIGN_W = 1,
    parameter  int EXPO_W = 8,
    parameter  int MANT_W = 23,
    parameter  int CNT_W  = 8,
    localparam int FP_W   = SIGN_W + EXPO_W + MANT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [FP_W-1:0]  in_fp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [FP_W-1:0]  out_fp,
    output logic             out_zero,
    output logic             busy
);

    localparam int MAG_W = EXPO_W + MANT_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [FP_W-1:0]   r_acc;
    logic              r_have_acc;
    logic [FP_W-1:0]   r_out_fp;
    logic              r_out_zero;
    logic              w_load;
    logic              w_take;
    logic [FP_W-1:0]   w_flush;
    logic [FP_W-1:0]   w_new_acc;

    // Sign-magnitude strict less-than; both magnitudes zero means -0 == +0.
    function automatic logic fp_lt(input logic [FP_W-1:0] a, input logic [FP_W-1:0] b);
        logic             sa;
        logic             sb;
        logic [MAG_W-1:0] ma;
        logic [MAG_W-1:0] mb;
        sa = a[FP_W-1];
        sb = b[FP_W-1];
        ma = a[MAG_W-1:0];
        mb = b[MAG_W-1:0];
        if (ma == '0 && mb == '0) return 1'b0;
        if (sa != sb)             return sa;
        if (!sa)                  return (ma < mb);
        return (ma > mb);
    endfunction

    assign w_flush   = (in_fp[MAG_W-1:MANT_W] == '0)
                     ? {in_fp[FP_W-1 -: SIGN_W], {MAG_W{1'b0}}} : in_fp;
    assign w_new_acc = (!r_have_acc || fp_lt(w_flush, r_acc)) ? w_flush : r_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        w_load      = 1'b0;
        w_take      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && len != '0) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                in_ready = 1'b1;
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (in_valid) begin
                    w_take = 1'b1;
                    if (r_cnt == CNT_W'(1)) w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (abort || out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_acc      <= '0;
            r_have_acc <= 1'b0;
            r_out_fp   <= '0;
            r_out_zero <= 1'b0;
        end else if (w_load) begin
            r_cnt      <= len;
            r_have_acc <= 1'b0;
        end else if (w_take) begin
            r_cnt      <= r_cnt - CNT_W'(1);
            r_acc      <= w_new_acc;
            r_have_acc <= 1'b1;
            // Result is captured on the final handshake so it is stable in DONE.
            if (r_cnt == CNT_W'(1)) begin
                r_out_fp   <= w_new_acc;
                r_out_zero <= (w_new_acc[MAG_W-1:MANT_W] == '0);
            end
        end
    end

    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign out_fp    = r_out_fp;
    assign out_zero  = r_out_zero;

endmodule
`default_nettype wire

// File: tb/tb_fp_min_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_min_seq
// Purpose  : Table-driven self-checking bench for fp_min_seq.
// Revision : 1.0
// ============================================================================
module tb_fp_min_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  len;
    logic        abort;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_fp;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_fp;
    logic        out_zero;
    logic        busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          n;
        logic [31:0] ops [4];
        logic [31:0] exp_fp;
        logic        exp_zero;
        int          stall;
        int          odly;
    } vec_t;

    vec_t vq[$];

    fp_min_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fp     (in_fp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_fp    (out_fp),
        .out_zero  (out_zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic add_vec(input int n, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c, input logic [31:0] d,
                           input logic [31:0] e, input logic z, input int st, input int od);
        vec_t v;
        v.n = n;
        v.ops[0] = a; v.ops[1] = b; v.ops[2] = c; v.ops[3] = d;
        v.exp_fp = e; v.exp_zero = z; v.stall = st; v.odly = od;
        vq.push_back(v);
    endtask

    task automatic run_job(input vec_t v);
        int cyc;
        int w;
        len   = 8'(v.n);
        start = 1'b1;
        tick;
        start = 1'b0;
        cyc   = 1;
        for (int i = 0; i < v.n; i++) begin
            if (i > 0) begin
                for (int s = 0; s < v.stall; s++) begin
                    in_valid = 1'b0;
                    tick;
                    cyc++;
                    chk("stall_busy", 32'(busy), 32'd1);
                end
            end
            in_valid = 1'b1;
            in_fp    = v.ops[i];
            w = 0;
            while (!in_ready && w < 10) begin
                tick;
                w++;
                cyc++;
            end
            if (!in_ready) chk("in_ready_wait", 32'(in_ready), 32'd1);
            tick;
            cyc++;
        end
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 20) begin
            tick;
            w++;
            cyc++;
        end
        chk("out_valid", 32'(out_valid), 32'd1);
        if (v.stall == 0) chk("latency", 32'(cyc), 32'(v.n + 1));
        chk("out_fp", out_fp, v.exp_fp);
        chk("out_zero", 32'(out_zero), 32'(v.exp_zero));
        for (int d = 0; d < v.odly; d++) begin
            tick;
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_fp", out_fp, v.exp_fp);
        end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        chk("valid_drop", 32'(out_valid), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        vec_t v;
        rst_n = 1'b0; start = 1'b0; len = '0; abort = 1'b0;
        in_valid = 1'b0; in_fp = '0; out_ready = 1'b0;

        // len, op0..op3, expected fp, expected zero, stall, out_ready delay
        add_vec(3, 32'h40400000, 32'hBFC00000, 32'h40000000, 32'h0, 32'hBFC00000, 1'b0, 0, 0);
        add_vec(2, 32'h3F800000, 32'h00000001, 32'h0, 32'h0, 32'h00000000, 1'b1, 0, 0);
        add_vec(2, 32'h80000000, 32'h00000000, 32'h0, 32'h0, 32'h80000000, 1'b1, 0, 0);
        add_vec(2, 32'h00000000, 32'h80000000, 32'h0, 32'h0, 32'h00000000, 1'b1, 0, 0);
        add_vec(4, 32'h3F800000, 32'hC0000000, 32'hC0400000, 32'h40000000, 32'hC0400000, 1'b0, 0, 0);
        add_vec(1, 32'h7F800000, 32'h0, 32'h0, 32'h0, 32'h7F800000, 1'b0, 0, 0);
        add_vec(3, 32'h7FFFFFFF, 32'h7F800000, 32'h40000000, 32'h0, 32'h40000000, 1'b0, 0, 0);
        add_vec(2, 32'h80000005, 32'h00000000, 32'h0, 32'h0, 32'h80000000, 1'b1, 0, 0);
        add_vec(3, 32'hC0000000, 32'hC0000000, 32'hBF800000, 32'h0, 32'hC0000000, 1'b0, 0, 0);
        add_vec(2, 32'h3F800000, 32'hBF800000, 32'h0, 32'h0, 32'hBF800000, 1'b0, 5, 0);
        add_vec(2, 32'h40000000, 32'h3F800000, 32'h0, 32'h0, 32'h3F800000, 1'b0, 0, 3);

        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_fp", out_fp, 32'd0);
        chk("rst_out_zero", 32'(out_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick;

        foreach (vq[k]) run_job(vq[k]);

        // start with len=0 is ignored
        len = 8'd0; start = 1'b1;
        tick;
        start = 1'b0;
        chk("len0_busy", 32'(busy), 32'd0);
        tick;
        chk("len0_busy2", 32'(busy), 32'd0);

        // abort after 2nd operand, colliding with a 3rd handshake
        len = 8'd4; start = 1'b1;
        tick;
        start = 1'b0;
        in_valid = 1'b1; in_fp = 32'h3F800000; tick;
        in_fp = 32'h40000000; tick;
        abort = 1'b1; in_fp = 32'h40400000; tick;
        abort = 1'b0; in_valid = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("abort_no_valid", 32'(out_valid), 32'd0);
        end
        v.n = 1; v.ops[0] = 32'hC0000000; v.ops[1] = '0; v.ops[2] = '0; v.ops[3] = '0;
        v.exp_fp = 32'hC0000000; v.exp_zero = 1'b0; v.stall = 0; v.odly = 0;
        run_job(v);

        // abort and start together in IDLE: start wins
        abort = 1'b1; start = 1'b1; len = 8'd1;
        tick;
        abort = 1'b0; start = 1'b0;
        chk("abort_start_busy", 32'(busy), 32'd1);
        in_valid = 1'b1; in_fp = 32'h40400000; tick;
        in_valid = 1'b0;
        chk("abort_start_valid", 32'(out_valid), 32'd1);
        chk("abort_start_fp", out_fp, 32'h40400000);
        out_ready = 1'b1; tick; out_ready = 1'b0;

        // start pulsed during RUN does not reload len
        len = 8'd2; start = 1'b1;
        tick;
        start = 1'b0;
        in_valid = 1'b1; in_fp = 32'h3F800000; tick;
        start = 1'b1; len = 8'd4; in_fp = 32'hBF800000; tick;
        start = 1'b0; in_valid = 1'b0;
        chk("restart_valid", 32'(out_valid), 32'd1);
        chk("restart_fp", out_fp, 32'hBF800000);
        out_ready = 1'b1; tick; out_ready = 1'b0;

        // asynchronous reset mid-RUN (out_fp still holds 0xBF800000)
        len = 8'd3; start = 1'b1;
        tick;
        start = 1'b0;
        in_valid = 1'b1; in_fp = 32'h3F800000; tick;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd0);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_fp", out_fp, 32'd0);
        chk("arst_out_zero", 32'(out_zero), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        chk("post_rst_busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
